exc_commit: RTL and testbench

Exception commit unit for the MIPS pipeline, placed at the MEM/WB boundary. It collects per-instruction exception flags from MEM, checks for pending interrupts against forwarded Status/Cause, and arbitrates by priority. It then emits the exception code, faulting address and delay-slot flag for the CP0 register block, together with the pipeline flush pulse and redirect PC. After each taken exception it holds a flush window in which new MEM inputs are ignored.

---
 rtl/exc_commit_if.sv | 47 ++++
 rtl/exc_commit.sv | 147 ++++++++++++++
 tb/tb_exc_commit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_if.sv
// Bundle of the MEM-stage instruction info, CP0 views, WB CP0 write port and
// the commit outputs that exc_commit drives toward CP0 and the pipeline.
interface exc_commit_if;
  // MEM stage instruction and its exception flags
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic        mem_syscall_i;
  logic        mem_invalid_i;
  logic        mem_ovf_i;
  logic        mem_trap_i;
  logic        mem_eret_i;
  // Current CP0 register contents
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  // WB stage CP0 write, used for forwarding
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  // Commit results
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  // Pipeline side: drives instruction/CP0 info, receives commit results
  modport master (
    output mem_valid_i, mem_pc_i, mem_in_delayslot_i,
    output mem_syscall_i, mem_invalid_i, mem_ovf_i, mem_trap_i, mem_eret_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    input  flush_o, new_pc_o
  );

  // Commit unit side
  modport slave (
    input  mem_valid_i, mem_pc_i, mem_in_delayslot_i,
    input  mem_syscall_i, mem_invalid_i, mem_ovf_i, mem_trap_i, mem_eret_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
    output flush_o, new_pc_o
  );
endinterface

// File: rtl/exc_commit.sv
// Exception commit unit at the MEM/WB boundary. Forwards pending WB CP0
// writes, detects interrupts, picks the highest-priority exception, emits a
// one-cycle commit pulse and then blanks MEM inputs for a flush window.
module exc_commit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic        clk,
  input logic        rst,
  exc_commit_if.slave bus
);

  localparam logic [4:0]  ADDR_STATUS = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE  = 5'd13;
  localparam logic [4:0]  ADDR_EPC    = 5'd14;

  localparam logic [31:0] CODE_INT  = 32'h1;
  localparam logic [31:0] CODE_INV  = 32'ha;
  localparam logic [31:0] CODE_SYS  = 32'h8;
  localparam logic [31:0] CODE_OVF  = 32'hc;
  localparam logic [31:0] CODE_TRAP = 32'hd;
  localparam logic [31:0] CODE_ERET = 32'he;

  // A window of one cycle means the commit cycle alone; no FLUSH state needed
  localparam bit         HAS_WINDOW = (FLUSH_CYCLES > 1);
  localparam logic [2:0] CNT_LOAD   = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;

  logic [31:0] status_fwd, cause_fwd, epc_fwd;
  logic        int_pending;
  logic [31:0] code;
  logic        take;

  logic [31:0] excepttype_reg;
  logic [31:0] inst_addr_reg;
  logic        delayslot_reg;
  logic        flush_reg;
  logic [31:0] new_pc_reg;

  // Effective CP0 view: a same-cycle WB write overrides the stored register
  always_comb begin
    status_fwd = bus.cp0_status_i;
    epc_fwd    = bus.cp0_epc_i;
    cause_fwd  = bus.cp0_cause_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == ADDR_STATUS)
      status_fwd = bus.wb_cp0_data_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == ADDR_EPC)
      epc_fwd = bus.wb_cp0_data_i;
    // Only the software-writable Cause fields (IP1:0, IV, WP) follow WB
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == ADDR_CAUSE) begin
      cause_fwd[9:8] = bus.wb_cp0_data_i[9:8];
      cause_fwd[23]  = bus.wb_cp0_data_i[23];
      cause_fwd[22]  = bus.wb_cp0_data_i[22];
    end
  end

  // Interrupt needs a masked pending line, IE set and EXL clear
  assign int_pending = (|(cause_fwd[15:8] & status_fwd[15:8])) &&
                       status_fwd[0] && !status_fwd[1];

  // Priority arbitration; lower-priority flags in the same cycle are dropped
  always_comb begin
    code = 32'h0;
    if (int_pending)            code = CODE_INT;
    else if (bus.mem_invalid_i) code = CODE_INV;
    else if (bus.mem_syscall_i) code = CODE_SYS;
    else if (bus.mem_ovf_i)     code = CODE_OVF;
    else if (bus.mem_trap_i)    code = CODE_TRAP;
    else if (bus.mem_eret_i)    code = CODE_ERET;
  end

  assign take = (state_reg == IDLE) && bus.mem_valid_i && (code != 32'h0);

  // FSM state and flush-window counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: enter the window on commit, leave once the count hits 1
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (take && HAS_WINDOW) begin
          state_next = FLUSH;
          cnt_next   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (cnt_reg <= 3'd1) begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Commit registers: pulses clear every non-commit edge, address/slot hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      excepttype_reg <= 32'h0;
      inst_addr_reg  <= 32'h0;
      delayslot_reg  <= 1'b0;
      flush_reg      <= 1'b0;
      new_pc_reg     <= 32'h0;
    end else if (take) begin
      excepttype_reg <= code;
      inst_addr_reg  <= bus.mem_pc_i;
      delayslot_reg  <= bus.mem_in_delayslot_i;
      flush_reg      <= 1'b1;
      new_pc_reg     <= (code == CODE_ERET) ? epc_fwd : HANDLER_ADDR;
    end else begin
      excepttype_reg <= 32'h0;
      flush_reg      <= 1'b0;
      new_pc_reg     <= 32'h0;
    end
  end

  assign bus.excepttype_o        = excepttype_reg;
  assign bus.current_inst_addr_o = inst_addr_reg;
  assign bus.is_in_delayslot_o   = delayslot_reg;
  assign bus.flush_o             = flush_reg;
  assign bus.new_pc_o            = new_pc_reg;

  // Register bits that play no part in commit decisions
  logic unused_bits;
  assign unused_bits = &{1'b0, status_fwd[31:16], status_fwd[7:2],
                         cause_fwd[31:16], cause_fwd[7:0]};

endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: a table of per-edge stimulus rows with
// hand-computed outputs, followed by hand-written reset sequences.
module tb_exc_commit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  exc_commit_if bus();

  exc_commit #(
    .HANDLER_ADDR(32'h0000_0020),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag mask layout: {syscall, invalid, ovf, trap, eret}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_SYS  = 5'b10000;
  localparam logic [4:0] F_INV  = 5'b01000;
  localparam logic [4:0] F_OVF  = 5'b00100;
  localparam logic [4:0] F_TRAP = 5'b00010;
  localparam logic [4:0] F_ERET = 5'b00001;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        ds;
    logic [4:0]  flags;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] e_type;
    logic [31:0] e_addr;
    logic        e_ds;
    logic        e_flush;
    logic [31:0] e_newpc;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vec [NVEC];

  function automatic vec_t mk(
    input logic v, input logic [31:0] pc, input logic ds, input logic [4:0] fl,
    input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep,
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [31:0] et, input logic [31:0] ea, input logic eds,
    input logic ef, input logic [31:0] enp);
    vec_t r;
    r.valid = v;  r.pc = pc;   r.ds = ds;   r.flags = fl;
    r.status = st; r.cause = ca; r.epc = ep;
    r.we = we;    r.waddr = wa; r.wdata = wd;
    r.e_type = et; r.e_addr = ea; r.e_ds = eds; r.e_flush = ef; r.e_newpc = enp;
    return r;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t r);
    bus.mem_valid_i        = r.valid;
    bus.mem_pc_i           = r.pc;
    bus.mem_in_delayslot_i = r.ds;
    bus.mem_syscall_i      = r.flags[4];
    bus.mem_invalid_i      = r.flags[3];
    bus.mem_ovf_i          = r.flags[2];
    bus.mem_trap_i         = r.flags[1];
    bus.mem_eret_i         = r.flags[0];
    bus.cp0_status_i       = r.status;
    bus.cp0_cause_i        = r.cause;
    bus.cp0_epc_i          = r.epc;
    bus.wb_cp0_we_i        = r.we;
    bus.wb_cp0_waddr_i     = r.waddr;
    bus.wb_cp0_data_i      = r.wdata;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] et, input logic [31:0] ea,
                               input logic eds, input logic ef, input logic [31:0] enp);
    check32({tag, " excepttype"}, bus.excepttype_o, et);
    check32({tag, " inst_addr"},  bus.current_inst_addr_o, ea);
    check32({tag, " delayslot"},  {31'h0, bus.is_in_delayslot_o}, {31'h0, eds});
    check32({tag, " flush"},      {31'h0, bus.flush_o}, {31'h0, ef});
    check32({tag, " new_pc"},     bus.new_pc_o, enp);
  endtask

  vec_t idle_row;
  vec_t r;

  initial begin
    checks = 0;
    errors = 0;

    // Each row: inputs sampled at one edge, outputs expected right after it
    vec[0]  = mk(0, 32'hBFC0_00F0, 0, F_SYS,  0, 0, 0, 0, 0, 0,  32'h0, 32'h0, 0, 0, 32'h0);
    vec[1]  = mk(1, 32'hBFC0_0100, 0, F_SYS,  0, 0, 0, 0, 0, 0,  32'h8, 32'hBFC0_0100, 0, 1, 32'h20);
    vec[2]  = mk(0, 32'h0, 0, F_NONE, 0, 0, 0, 0, 0, 0,  32'h0, 32'hBFC0_0100, 0, 0, 32'h0);
    vec[3]  = mk(1, 32'h1000, 1, F_OVF | F_INV, 0, 0, 0, 0, 0, 0,  32'ha, 32'h1000, 1, 1, 32'h20);
    vec[4]  = mk(1, 32'h1004, 0, F_OVF, 0, 0, 0, 0, 0, 0,  32'h0, 32'h1000, 1, 0, 32'h0);
    vec[5]  = mk(1, 32'h2000, 0, F_SYS, 32'h401, 32'h400, 0, 0, 0, 0,  32'h1, 32'h2000, 0, 1, 32'h20);
    vec[6]  = mk(0, 32'h0, 0, F_NONE, 0, 0, 0, 0, 0, 0,  32'h0, 32'h2000, 0, 0, 32'h0);
    vec[7]  = mk(1, 32'h3000, 0, F_NONE, 32'h401, 32'h400, 0, 1, 5'd12, 32'h400,  32'h0, 32'h2000, 0, 0, 32'h0);
    vec[8]  = mk(1, 32'h3000, 0, F_SYS, 32'h400, 32'h400, 0, 0, 0, 0,  32'h8, 32'h3000, 0, 1, 32'h20);
    vec[9]  = mk(0, 32'h0, 0, F_NONE, 0, 0, 0, 0, 0, 0,  32'h0, 32'h3000, 0, 0, 32'h0);
    vec[10] = mk(1, 32'h4000, 0, F_ERET, 0, 0, 32'h100, 1, 5'd14, 32'h200,  32'he, 32'h4000, 0, 1, 32'h200);
    vec[11] = mk(0, 32'h0, 0, F_NONE, 0, 0, 0, 0, 0, 0,  32'h0, 32'h4000, 0, 0, 32'h0);
    vec[12] = mk(1, 32'h4004, 0, F_ERET, 0, 0, 32'h100, 0, 0, 0,  32'he, 32'h4004, 0, 1, 32'h100);
    vec[13] = mk(0, 32'h0, 0, F_NONE, 0, 0, 0, 0, 0, 0,  32'h0, 32'h4004, 0, 0, 32'h0);
    vec[14] = mk(1, 32'h5000, 1, F_TRAP, 0, 0, 0, 0, 0, 0,  32'hd, 32'h5000, 1, 1, 32'h20);
    vec[15] = mk(0, 32'h0, 0, F_NONE, 0, 0, 0, 0, 0, 0,  32'h0, 32'h5000, 1, 0, 32'h0);
    vec[16] = mk(1, 32'h6000, 0, F_OVF | F_TRAP | F_ERET, 0, 0, 32'h100, 0, 0, 0,  32'hc, 32'h6000, 0, 1, 32'h20);
    vec[17] = mk(0, 32'h0, 0, F_NONE, 0, 0, 0, 0, 0, 0,  32'h0, 32'h6000, 0, 0, 32'h0);
    vec[18] = mk(1, 32'h7000, 0, F_NONE, 32'h201, 32'h0, 0, 1, 5'd13, 32'h200,  32'h1, 32'h7000, 0, 1, 32'h20);
    vec[19] = mk(0, 32'h0, 0, F_NONE, 0, 0, 0, 0, 0, 0,  32'h0, 32'h7000, 0, 0, 32'h0);
    vec[20] = mk(1, 32'h7100, 0, F_NONE, 32'h801, 32'h0, 0, 1, 5'd13, 32'h800,  32'h0, 32'h7000, 0, 0, 32'h0);
    vec[21] = mk(1, 32'h7200, 0, F_NONE, 32'h403, 32'h400, 0, 0, 0, 0,  32'h0, 32'h7000, 0, 0, 32'h0);
    vec[22] = mk(1, 32'h8000, 0, F_SYS, 0, 0, 0, 0, 0, 0,  32'h8, 32'h8000, 0, 1, 32'h20);
    vec[23] = mk(1, 32'h8004, 0, F_SYS, 0, 0, 0, 0, 0, 0,  32'h0, 32'h8000, 0, 0, 32'h0);
    vec[24] = mk(1, 32'h8008, 1, F_SYS, 0, 0, 0, 0, 0, 0,  32'h8, 32'h8008, 1, 1, 32'h20);
    vec[25] = mk(0, 32'h0, 0, F_NONE, 0, 0, 0, 0, 0, 0,  32'h0, 32'h8008, 1, 0, 32'h0);

    idle_row = mk(0, 32'h0, 0, F_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    rst = 1'b0;
    apply(idle_row);
    #3;
    check_outputs("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    $display("txn reset: excepttype=%h flush=%b", bus.excepttype_o, bus.flush_o);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      apply(vec[i]);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vec[i].e_type, vec[i].e_addr,
                    vec[i].e_ds, vec[i].e_flush, vec[i].e_newpc);
      $display("txn %0d: pc=%h excepttype=%h flush=%b new_pc=%h", i, vec[i].pc,
               bus.excepttype_o, bus.flush_o, bus.new_pc_o);
    end

    // Reset asserted in the FLUSH cycle clears outputs without a clock edge
    @(negedge clk);
    r = mk(1, 32'hA000, 1, F_SYS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(r);
    @(posedge clk);
    #1;
    check_outputs("pre_rst", 32'h8, 32'hA000, 1'b1, 1'b1, 32'h20);
    #1;
    rst = 1'b0;
    #1;
    check_outputs("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    $display("txn async_rst: excepttype=%h flush=%b", bus.excepttype_o, bus.flush_o);

    // First edge after release may commit
    @(negedge clk);
    rst = 1'b1;
    r = mk(1, 32'hB000, 0, F_SYS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(r);
    @(posedge clk);
    #1;
    check_outputs("post_rst", 32'h8, 32'hB000, 1'b0, 1'b1, 32'h20);
    $display("txn post_rst: excepttype=%h flush=%b", bus.excepttype_o, bus.flush_o);

    @(negedge clk);
    apply(idle_row);
    @(posedge clk);
    #1;
    check_outputs("post_rst_idle", 32'h0, 32'hB000, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
